mac_pipeline: RTL and testbench



---
 rtl/mac_pipeline_pkg.sv | 21 ++
 rtl/mac_pipeline_sat_add.sv | 32 +++
 rtl/mac_pipeline.sv | 108 ++++++++++
 tb/tb_mac_pipeline.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pipeline_pkg.sv
// rtl/mac_pipeline_pkg.sv - shared widths, mode encoding and stage-1 layout for mac_pipeline
package mac_pipeline_pkg;

    localparam int DATA_WIDTH     = 8;
    localparam int DATA_OUT_WIDTH = 20;

    typedef enum logic {
        MAC_SINGLE = 1'b0,
        MAC_ACCUM  = 1'b1
    } mac_mode_e;

    // Stage-1 register layout at the default widths
    typedef struct packed {
        logic [2*DATA_WIDTH-1:0] product;
        logic [DATA_WIDTH-1:0]   c;
        mac_mode_e               mode;
        logic                    first;
        logic                    valid;
    } s1_t;

endpackage

// File: rtl/mac_pipeline_sat_add.sv
// rtl/mac_pipeline_sat_add.sv - stage-2 adder with overflow detect; clamps under MAC_SATURATE_EN, wraps otherwise
module mac_pipeline_sat_add #(
    parameter int DATA_WIDTH = mac_pipeline_pkg::DATA_WIDTH,
    parameter int ACC_WIDTH  = mac_pipeline_pkg::DATA_OUT_WIDTH
) (
    input  logic [2*DATA_WIDTH-1:0] i_product,
    input  logic [DATA_WIDTH-1:0]   i_c,
    input  logic [ACC_WIDTH-1:0]    i_acc,
    input  logic                    i_use_acc,
    output logic [ACC_WIDTH-1:0]    o_result,
    output logic                    o_ovf
);

    logic [ACC_WIDTH:0] w_product_ext;
    logic [ACC_WIDTH:0] w_addend;
    logic [ACC_WIDTH:0] w_sum;

    // One extra bit of sum width catches the carry out of the result width
    always_comb begin
        w_product_ext = {{(ACC_WIDTH+1-2*DATA_WIDTH){1'b0}}, i_product};
        w_addend      = i_use_acc ? {1'b0, i_acc}
                                  : {{(ACC_WIDTH+1-DATA_WIDTH){1'b0}}, i_c};
        w_sum         = w_product_ext + w_addend;
        o_ovf         = w_sum[ACC_WIDTH];
`ifdef MAC_SATURATE_EN
        o_result      = w_sum[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : w_sum[ACC_WIDTH-1:0];
`else
        o_result      = w_sum[ACC_WIDTH-1:0];
`endif
    end

endmodule

// File: rtl/mac_pipeline.sv
// rtl/mac_pipeline.sv - two-stage pipelined multiply-accumulate with valid/ready; optional MAC_SATURATE_EN clamps on overflow
module mac_pipeline
    import mac_pipeline_pkg::*;
#(
    parameter int DATA_WIDTH = mac_pipeline_pkg::DATA_WIDTH,
    parameter int ACC_WIDTH  = mac_pipeline_pkg::DATA_OUT_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic [DATA_WIDTH-1:0] c,
    input  logic                  mode,
    input  logic                  first,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ACC_WIDTH-1:0]  data_out,
    output logic                  out_ovf
);

    generate
        if (ACC_WIDTH < 2*DATA_WIDTH+1) begin : g_width_check
            $error("mac_pipeline: ACC_WIDTH must be at least 2*DATA_WIDTH+1");
        end
    endgenerate

    // Same field layout as s1_t, but sized from this instance's parameters
    typedef struct packed {
        logic [2*DATA_WIDTH-1:0] product;
        logic [DATA_WIDTH-1:0]   c;
        mac_mode_e               mode;
        logic                    first;
        logic                    valid;
    } s1_w_t;

    s1_w_t                   r_s1;
    logic                    r_out_valid;
    logic [ACC_WIDTH-1:0]    r_data_out;
    logic                    r_out_ovf;
    logic [ACC_WIDTH-1:0]    r_acc;

    logic                    w_stall;
    logic                    w_in_xfer;
    logic                    w_use_acc;
    logic [2*DATA_WIDTH-1:0] w_product;
    logic [ACC_WIDTH-1:0]    w_result;
    logic                    w_ovf;

    // A full output register that the consumer refuses freezes the whole pipe
    assign w_stall   = r_out_valid && !out_ready;
    assign in_ready  = !w_stall;
    assign w_in_xfer = in_valid && !w_stall;
    assign w_product = {{DATA_WIDTH{1'b0}}, a} * {{DATA_WIDTH{1'b0}}, b};
    assign w_use_acc = (r_s1.mode == MAC_ACCUM) && !r_s1.first;

    assign out_valid = r_out_valid;
    assign data_out  = r_data_out;
    assign out_ovf   = r_out_ovf;

    mac_pipeline_sat_add #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
    ) u_sat_add (
        .i_product (r_s1.product),
        .i_c       (r_s1.c),
        .i_acc     (r_acc),
        .i_use_acc (w_use_acc),
        .o_result  (w_result),
        .o_ovf     (w_ovf)
    );

    // Stage 1: capture the product and beat controls; idle cycles shift in a bubble
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1 <= '0;
        end else if (!w_stall) begin
            r_s1.valid <= w_in_xfer;
            if (w_in_xfer) begin
                r_s1.product <= w_product;
                r_s1.c       <= c;
                r_s1.mode    <= mac_mode_e'(mode);
                r_s1.first   <= first;
            end
        end
    end

    // Stage 2: register the result; only ACCUM beats update the running accumulator
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_data_out  <= '0;
            r_out_ovf   <= 1'b0;
            r_acc       <= '0;
        end else if (!w_stall) begin
            r_out_valid <= r_s1.valid;
            if (r_s1.valid) begin
                r_data_out <= w_result;
                r_out_ovf  <= w_ovf;
                if (r_s1.mode == MAC_ACCUM) begin
                    r_acc <= w_result;
                end
            end
        end
    end

endmodule

// File: tb/tb_mac_pipeline.sv
// tb/tb_mac_pipeline.sv - randomized and directed self-checking bench for mac_pipeline
module tb_mac_pipeline;

    localparam longint LIM = 64'd1 << 20;
`ifdef MAC_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a, b, c;
    logic        mode, first;
    logic        out_valid;
    logic        out_ready;
    logic [19:0] data_out;
    logic        out_ovf;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [20:0] exp_q[$];
    logic [20:0] obs_q[$];
    int          obs_cyc[$];
    longint      model_acc = 0;

    mac_pipeline #(.DATA_WIDTH(8), .ACC_WIDTH(20)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c         (c),
        .mode      (mode),
        .first     (first),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: result of one accepted beat from the arithmetic rules, in acceptance order
    function automatic logic [20:0] model_beat(input logic [7:0] ia, ib, ic, input logic im, ifst);
        longint p, sum, res;
        logic   ovf;
        p   = longint'(ia) * longint'(ib);
        sum = (im && !ifst) ? model_acc + p : p + longint'(ic);
        ovf = (sum >= LIM);
        res = ovf ? (SAT ? LIM - 1 : sum - LIM) : sum;
        if (im) model_acc = res;
        return {ovf, res[19:0]};
    endfunction

    // Record accepted inputs (as model results) and delivered outputs
    always @(negedge clk) begin
        if (!reset) begin
            if (in_valid && in_ready) exp_q.push_back(model_beat(a, b, c, mode, first));
            if (out_valid && out_ready) begin
                obs_q.push_back({out_ovf, data_out});
                obs_cyc.push_back(cyc);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; a = '0; b = '0; c = '0; mode = 1'b0; first = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        cycle();
        cycle();
        exp_q.delete(); obs_q.delete(); obs_cyc.delete();
        model_acc = 0;
        reset = 1'b0;
    endtask

    task automatic offer(input logic [7:0] ia, ib, ic, input logic im, ifst, output bit ok);
        bit rdy;
        in_valid = 1'b1; a = ia; b = ib; c = ic; mode = im; first = ifst;
        ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            rdy = in_ready;
            cycle();
            if (rdy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_obs(input int n, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 300; k++) begin
            if (obs_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
            cycle();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; out_ready = 1'b0;
        idle_inputs();
        cycle();
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (data_out !== 20'd0) begin errors++; $display("FAIL reset_data_out: got %0d expected 0", data_out); end
        checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL reset_out_ovf: got %b expected 0", out_ovf); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        cycle();
        reset = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic test_single();
        bit ok;
        do_reset();
        out_ready = 1'b1;
        offer(8'd3, 8'd4, 8'd5, 1'b0, 1'b0, ok);
        idle_inputs();
        checks++; if (!ok) begin errors++; $display("FAIL single_accept: got not accepted expected accepted"); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_latency_early: out_valid got %b expected 0", out_valid); end
        @(posedge clk);
        @(negedge clk);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_latency: out_valid got %b expected 1", out_valid); end
        checks++; if (data_out !== 20'd17) begin errors++; $display("FAIL single_data: got %0d expected 17", data_out); end
        checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL single_ovf: got %b expected 0", out_ovf); end
        cycle();
    endtask

    task automatic test_accum();
        bit ok;
        logic [20:0] r;
        int expv[5] = '{7, 27, 28, 1, 29};
        do_reset();
        out_ready = 1'b1;
        offer(8'd2, 8'd3, 8'd1, 1'b1, 1'b1, ok);
        offer(8'd4, 8'd5, 8'd0, 1'b1, 1'b0, ok);
        offer(8'd1, 8'd1, 8'd0, 1'b1, 1'b0, ok);
        offer(8'd1, 8'd1, 8'd0, 1'b0, 1'b0, ok);
        offer(8'd1, 8'd1, 8'd0, 1'b1, 1'b0, ok);
        idle_inputs();
        wait_obs(5, ok);
        checks++; if (!ok) begin errors++; $display("FAIL accum_count: got %0d results expected 5", obs_q.size()); end
        else begin
            for (int i = 0; i < 5; i++) begin
                r = obs_q[i];
                checks++;
                if (r !== {1'b0, expv[i][19:0]}) begin
                    errors++; $display("FAIL accum_value[%0d]: got %0d ovf %b expected %0d ovf 0", i, r[19:0], r[20], expv[i]);
                end
                checks++;
                if (obs_cyc[i] !== obs_cyc[0] + i) begin
                    errors++; $display("FAIL accum_consecutive[%0d]: got cycle %0d expected %0d", i, obs_cyc[i], obs_cyc[0] + i);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        logic [20:0] r;
        int expv[3] = '{5, 20, 110};
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; a = 8'd1; b = 8'd2; c = 8'd3; mode = 1'b0; first = 1'b0;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_beat1: got %b expected 1", in_ready); end
        cycle();
        a = 8'd4; b = 8'd4; c = 8'd4;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_beat2: got %b expected 1", in_ready); end
        cycle();
        a = 8'd10; b = 8'd10; c = 8'd10;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_stall_ready[%0d]: got %b expected 0", k, in_ready); end
            checks++; if (out_valid !== 1'b1 || data_out !== 20'd5) begin
                errors++; $display("FAIL bp_stall_hold[%0d]: got valid %b data %0d expected valid 1 data 5", k, out_valid, data_out);
            end
            cycle();
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b expected 1", in_ready); end
        cycle();
        idle_inputs();
        wait_obs(3, ok);
        repeat (5) cycle();
        checks++; if (obs_q.size() != 3) begin errors++; $display("FAIL bp_count: got %0d results expected 3", obs_q.size()); end
        else begin
            for (int i = 0; i < 3; i++) begin
                r = obs_q[i];
                checks++;
                if (r !== {1'b0, expv[i][19:0]}) begin
                    errors++; $display("FAIL bp_value[%0d]: got %0d expected %0d", i, r[19:0], expv[i]);
                end
            end
        end
    endtask

    task automatic test_overflow();
        bit ok;
        logic [20:0] r;
        logic [19:0] exp17;
        exp17 = SAT ? 20'd1048575 : 20'd57104;
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            offer(8'd255, 8'd255, (i == 0) ? 8'd255 : 8'd0, 1'b1, (i == 0), ok);
        end
        idle_inputs();
        wait_obs(17, ok);
        checks++; if (!ok) begin errors++; $display("FAIL ovf_count: got %0d results expected 17", obs_q.size()); end
        else begin
            r = obs_q[15];
            checks++; if (r !== {1'b0, 20'd1040655}) begin errors++; $display("FAIL ovf_beat16: got %0d ovf %b expected 1040655 ovf 0", r[19:0], r[20]); end
            r = obs_q[16];
            checks++; if (r[19:0] !== exp17) begin errors++; $display("FAIL ovf_beat17_data: got %0d expected %0d", r[19:0], exp17); end
            checks++; if (r[20] !== 1'b1) begin errors++; $display("FAIL ovf_beat17_flag: got %b expected 1", r[20]); end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        logic [20:0] r;
        do_reset();
        out_ready = 1'b1;
        offer(8'd10, 8'd10, 8'd0, 1'b1, 1'b1, ok);
        idle_inputs();
        wait_obs(1, ok);
        offer(8'd3, 8'd3, 8'd0, 1'b1, 1'b0, ok);
        offer(8'd5, 8'd5, 8'd0, 1'b1, 1'b0, ok);
        reset = 1'b1;
        idle_inputs();
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid: got %b expected 0", out_valid); end
        cycle();
        exp_q.delete(); obs_q.delete(); obs_cyc.delete();
        model_acc = 0;
        reset = 1'b0;
        repeat (6) cycle();
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL rstmid_spurious: got %0d results expected 0", obs_q.size()); end
        offer(8'd2, 8'd2, 8'd0, 1'b1, 1'b0, ok);
        idle_inputs();
        wait_obs(1, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rstmid_next_timeout: got no result expected 1"); end
        else begin
            r = obs_q[0];
            checks++; if (r !== {1'b0, 20'd4}) begin errors++; $display("FAIL rstmid_next_value: got %0d ovf %b expected 4 ovf 0", r[19:0], r[20]); end
        end
    endtask

    task automatic test_max_single();
        bit ok;
        logic [20:0] r;
        do_reset();
        out_ready = 1'b1;
        offer(8'd255, 8'd255, 8'd255, 1'b0, 1'b0, ok);
        idle_inputs();
        wait_obs(1, ok);
        checks++; if (!ok) begin errors++; $display("FAIL max_timeout: got no result expected 1"); end
        else begin
            r = obs_q[0];
            checks++; if (r !== {1'b0, 20'd65280}) begin errors++; $display("FAIL max_value: got %0d ovf %b expected 65280 ovf 0", r[19:0], r[20]); end
        end
    endtask

    task automatic test_random();
        bit          ok;
        bit          prev_stall;
        logic [19:0] held;
        logic [20:0] r, e;
        int          n;
        do_reset();
        prev_stall = 1'b0;
        held = '0;
        for (int k = 0; k < 400; k++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            a = 8'($urandom); b = 8'($urandom); c = 8'($urandom);
            mode  = 1'($urandom);
            first = ($urandom_range(0, 31) == 0);
            @(negedge clk);
            checks++;
            if (in_ready !== !(out_valid && !out_ready)) begin
                errors++; $display("FAIL rand_in_ready[%0d]: got %b expected %b", k, in_ready, !(out_valid && !out_ready));
            end
            if (prev_stall) begin
                checks++;
                if (out_valid !== 1'b1 || data_out !== held) begin
                    errors++; $display("FAIL rand_stall_hold[%0d]: got valid %b data %0d expected valid 1 data %0d", k, out_valid, data_out, held);
                end
            end
            prev_stall = out_valid && !out_ready;
            held = data_out;
            cycle();
        end
        idle_inputs();
        out_ready = 1'b1;
        cycle();
        cycle();
        n = exp_q.size();
        wait_obs(n, ok);
        repeat (4) cycle();
        checks++; if (obs_q.size() != n) begin errors++; $display("FAIL rand_count: got %0d results expected %0d", obs_q.size(), n); end
        for (int i = 0; i < n && i < obs_q.size(); i++) begin
            r = obs_q[i];
            e = exp_q[i];
            checks++;
            if (r !== e) begin
                errors++; $display("FAIL rand_value[%0d]: got %0d ovf %b expected %0d ovf %b", i, r[19:0], r[20], e[19:0], e[20]);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        out_ready = 1'b1;
        idle_inputs();
        test_reset();
        test_single();
        test_accum();
        test_backpressure();
        test_overflow();
        test_reset_mid();
        test_max_single();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
